// File: rtl/pixel_unpacker.sv
// ============================================================================
// pixel_unpacker : unpacks RGB888 pixels (4 per 3 x 32-bit words) from AXI4-Stream
// Revision 1.0   : initial release
// ============================================================================
`default_nettype none

module pixel_unpacker #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic [9:0]  out_x,
  output logic [8:0]  out_y,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_sof,
  output logic        err_eol,
  output logic        err_keep,
  input  logic        err_clear
);

  localparam logic [9:0] c_X_LAST = 10'(X_SIZE - 1);
  localparam logic [9:0] c_X_PEN  = 10'(X_SIZE - 2);
  localparam logic [8:0] c_Y_LAST = 9'(Y_SIZE - 1);

  typedef enum logic [0:0] {
    S_WAIT_SOF = 1'b0,
    S_RUN      = 1'b1
  } state_t;

  state_t      r_state;
  logic [1:0]  r_phase;
  logic [15:0] r_res;
  logic        r_pending;
  logic [23:0] r_pend_pix;
  logic        r_pend_early;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic        r_out_valid;
  logic [23:0] r_out_pix;
  logic [9:0]  r_out_x;
  logic [8:0]  r_out_y;
  logic        r_out_sof;
  logic        r_out_eol;
  logic        r_err_sof;
  logic        r_err_eol;
  logic        r_err_keep;

  logic        w_out_free;
  logic        w_tready;
  logic        w_acc;
  logic        w_resync;
  logic        w_use;
  logic [1:0]  w_phase;
  logic [9:0]  w_x;
  logic [8:0]  w_y;
  logic [23:0] w_pix;
  logic        w_line_end;
  logic        w_early;
  logic        w_eol_err;
  logic        w_sof_err;
  logic        w_keep_err;
  logic        w_pend_load;
  logic        w_ld;
  logic [23:0] w_ld_pix;
  logic [9:0]  w_ld_x;
  logic [8:0]  w_ld_y;
  logic        w_frame_done;

  function automatic logic [9:0] f_x_next(input logic [9:0] x);
    return (x == c_X_LAST) ? 10'd0 : x + 10'd1;
  endfunction

  function automatic logic [8:0] f_y_inc(input logic [8:0] y);
    return (y == c_Y_LAST) ? 9'd0 : y + 9'd1;
  endfunction

  function automatic logic [8:0] f_y_adv(input logic [9:0] x, input logic [8:0] y);
    return (x == c_X_LAST) ? f_y_inc(y) : y;
  endfunction

  assign w_out_free = !r_out_valid || out_ready;
  assign w_tready   = !areset && !r_pending && w_out_free;
  assign w_acc      = in_stream_tvalid && w_tready;
  assign w_resync   = w_acc && in_stream_tuser;
  assign w_use      = w_acc && ((r_state == S_RUN) || in_stream_tuser);

  // A start-of-frame word always decodes as the first word of a fresh frame
  assign w_phase = w_resync ? 2'd0  : r_phase;
  assign w_x     = w_resync ? 10'd0 : r_x;
  assign w_y     = w_resync ? 9'd0  : r_y;

  always_comb begin
    w_pix = 24'h0;
    if (w_phase == 2'd0)
      w_pix = in_stream_tdata[23:0];
    else if (w_phase == 2'd1)
      w_pix = {in_stream_tdata[15:0], r_res[7:0]};
    else
      w_pix = {in_stream_tdata[7:0], r_res[15:0]};
  end

  // The phase-2 word carrying the pending pixel at X_SIZE-1 closes the line
  assign w_line_end = (w_phase == 2'd2) && (w_x == c_X_PEN);
  assign w_early    = w_use && in_stream_tlast && !w_line_end;
  assign w_eol_err  = w_use && (in_stream_tlast != w_line_end);
  assign w_sof_err  = w_resync && (r_state == S_RUN) &&
                      ((r_phase != 2'd0) || (r_x != 10'd0) || (r_y != 9'd0));
  assign w_keep_err = w_acc && (in_stream_tkeep != 4'hF);

  assign w_pend_load  = r_pending && w_out_free;
  assign w_ld         = w_use || w_pend_load;
  assign w_ld_pix     = w_use ? w_pix : r_pend_pix;
  assign w_ld_x       = w_use ? w_x : r_x;
  assign w_ld_y       = w_use ? w_y : r_y;
  assign w_frame_done = w_ld && (w_ld_x == c_X_LAST) && (w_ld_y == c_Y_LAST);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= S_WAIT_SOF;
      r_phase      <= 2'd0;
      r_res        <= 16'h0;
      r_pending    <= 1'b0;
      r_pend_pix   <= 24'h0;
      r_pend_early <= 1'b0;
      r_x          <= 10'd0;
      r_y          <= 9'd0;
      r_out_valid  <= 1'b0;
      r_out_pix    <= 24'h0;
      r_out_x      <= 10'd0;
      r_out_y      <= 9'd0;
      r_out_sof    <= 1'b0;
      r_out_eol    <= 1'b0;
      r_err_sof    <= 1'b0;
      r_err_eol    <= 1'b0;
      r_err_keep   <= 1'b0;
    end else begin
      if (w_ld) begin
        r_out_valid <= 1'b1;
        r_out_pix   <= w_ld_pix;
        r_out_x     <= w_ld_x;
        r_out_y     <= w_ld_y;
        r_out_sof   <= (w_ld_x == 10'd0) && (w_ld_y == 9'd0);
        r_out_eol   <= (w_ld_x == c_X_LAST);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_use) begin
        r_state <= S_RUN;
        if (w_phase == 2'd0) begin
          r_res <= {8'h00, in_stream_tdata[31:24]};
        end else if (w_phase == 2'd1) begin
          r_res <= in_stream_tdata[31:16];
        end
        if (w_phase == 2'd2) begin
          r_pending    <= 1'b1;
          r_pend_pix   <= in_stream_tdata[31:8];
          r_pend_early <= w_early;
          r_phase      <= 2'd0;
          r_x          <= f_x_next(w_x);
          r_y          <= f_y_adv(w_x, w_y);
        end else if (w_early) begin
          r_phase <= 2'd0;
          r_x     <= 10'd0;
          r_y     <= f_y_inc(w_y);
        end else begin
          r_phase <= w_phase + 2'd1;
          r_x     <= f_x_next(w_x);
          r_y     <= f_y_adv(w_x, w_y);
        end
      end

      if (w_pend_load) begin
        r_pending <= 1'b0;
        if (r_pend_early) begin
          r_x <= 10'd0;
          r_y <= f_y_inc(r_y);
        end else begin
          r_x <= f_x_next(r_x);
          r_y <= f_y_adv(r_x, r_y);
        end
      end

      if (w_frame_done) r_state <= S_WAIT_SOF;

      r_err_sof  <= w_sof_err  ? 1'b1 : (err_clear ? 1'b0 : r_err_sof);
      r_err_eol  <= w_eol_err  ? 1'b1 : (err_clear ? 1'b0 : r_err_eol);
      r_err_keep <= w_keep_err ? 1'b1 : (err_clear ? 1'b0 : r_err_keep);
    end
  end

  assign in_stream_tready = w_tready;
  assign out_r            = r_out_pix[23:16];
  assign out_g            = r_out_pix[15:8];
  assign out_b            = r_out_pix[7:0];
  assign out_x            = r_out_x;
  assign out_y            = r_out_y;
  assign out_sof          = r_out_sof;
  assign out_eol          = r_out_eol;
  assign out_valid        = r_out_valid;
  assign err_sof          = r_err_sof;
  assign err_eol          = r_err_eol;
  assign err_keep         = r_err_keep;

endmodule

`default_nettype wire
